// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, small FIFO, LSB-first serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit after data bit 7 (8E1, 11-bit frame).
module uart_tx #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [7:0]    LAST_TICK = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [2:0]    index_q, index_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, serial_q, active_q, done_q;
    logic          serial_d, done_d;
    logic          wr_en, pop, fifo_empty, bit_end;

    assign wr_en      = i_Tx_DV && ready_q;
    assign fifo_empty = (count_q == '0);
    assign bit_end    = (timer_q == LAST_TICK);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 8'd1;
        index_d = index_q;
        shift_d = shift_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    index_d = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    index_d = index_q + 3'd1;
                    if (index_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    done_d  = 1'b1;
                    // Chain straight into the next start bit so queued frames stay contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                timer_d = '0;
                index_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so the serial output is a plain register.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[index_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_d = ^shift_d;
`endif
            default:  serial_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            index_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            index_q  <= index_d;
            count_q  <= count_d;
            ready_q  <= (count_d != FULL);
            serial_q <= serial_d;
            active_q <= (state_d != S_IDLE);
            done_q   <= done_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        shift_q <= shift_d;
        if (wr_en) mem[wr_ptr_q] <= i_Tx_Byte;
    end

    assign o_Tx_Ready  = ready_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a serial-line receiver model checks every frame
// against the bytes the stimulus wrote.
module tb_uart_tx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       ready, serial, active, done;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_l),
        .i_Tx_DV    (dv),
        .i_Tx_Byte  (tx_byte),
        .o_Tx_Ready (ready),
        .o_Tx_Serial(serial),
        .o_Tx_Active(active),
        .o_Tx_Done  (done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         frames = 0;
    int         dones = 0;
    int         act_cycles = 0;
    longint     cyc = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q[$];
    longint     start_q[$];
`ifdef UART_TX_PARITY_EN
    logic       par_q[$];
`endif

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) dones <= dones + 1;
        if (active === 1'b1) act_cycles <= act_cycles + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Receiver model: samples each bit at its centre, timing taken from the start-bit edge.
    initial begin : monitor
        logic [7:0] b;
        longint     t0;
        bit         at_start;
        at_start = 1'b0;
        forever begin
            if (!at_start) @(negedge clk);
            at_start = 1'b0;
            if (mon_en && serial === 1'b0) begin
                t0 = cyc;
                start_q.push_back(t0);
                repeat (CPB / 2) @(negedge clk);
                check("start_bit", serial, 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = serial;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                check("parity_bit", serial, ^b);
                par_q.push_back(serial);
`endif
                repeat (CPB) @(negedge clk);
                check("stop_bit", serial, 1'b1);
                check("active_in_frame", active, 1'b1);
                check("done_early", done, 1'b0);
                repeat (CPB - CPB / 2) @(negedge clk);
                check("done_pulse", done, 1'b1);
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got byte %0d, expected no frame", b);
                end else begin
                    check("rx_byte", b, exp_q.pop_front());
                end
                at_start = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #(10 * 200000);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active !== 1'b0) && n < 20 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send_gated(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%0d, expected 1", ready);
        end else begin
            exp_q.push_back(b);
            dv      = 1'b1;
            tx_byte = b;
            @(negedge clk);
            dv = 1'b0;
        end
    endtask

    initial begin : stimulus
        int         d0, a0, f0, lows;
        longint     wr_cyc;
        logic [7:0] v[6];

        // Reset
        repeat (3) @(negedge clk);
        check("rst_serial", serial, 1'b1);
        check("rst_active", active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", ready, 1'b1);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_serial", serial, 1'b1);

        // Single byte 0xA5: latency, frame length, one done pulse
        start_q.delete();
        d0 = dones;
        a0 = act_cycles;
        exp_q.push_back(8'hA5);
        dv      = 1'b1;
        tx_byte = 8'hA5;
        @(negedge clk);
        dv     = 1'b0;
        wr_cyc = cyc;
        check("no_bypass", serial, 1'b1);
        drain();
        check("a5_frames", start_q.size(), 1);
        if (start_q.size() == 1) check("a5_latency", start_q[0] - wr_cyc, 1);
        check("a5_done_count", dones - d0, 1);
        check("a5_active_cycles", act_cycles - a0, FRAME);

        // Three writes in consecutive cycles: contiguous frames
        start_q.delete();
        d0 = dones;
        a0 = act_cycles;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        dv = 1'b1;
        tx_byte = 8'h00;
        @(negedge clk) tx_byte = 8'hFF;
        @(negedge clk) tx_byte = 8'h55;
        @(negedge clk) dv = 1'b0;
        drain();
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap_1", start_q[1] - start_q[0], FRAME);
            check("b2b_gap_2", start_q[2] - start_q[1], FRAME);
        end
        check("b2b_done_count", dones - d0, 3);
        check("b2b_active_cycles", act_cycles - a0, 3 * FRAME);

        // Six writes back-to-back: one popped, four queued, sixth dropped
        f0 = frames;
        for (int i = 0; i < 6; i++) v[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) exp_q.push_back(v[i]);
        dv      = 1'b1;
        tx_byte = v[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("burst_ready_%0d", i), ready, (i < 4) ? 1'b1 : 1'b0);
            if (i < 5) tx_byte = v[i + 1];
            else dv = 1'b0;
        end
        drain();
        check("burst_frames", frames - f0, 5);
        check("burst_ready_after", ready, 1'b1);

        // Reset during data bit 3 of 0x3C with two bytes queued
        mon_en  = 1'b0;
        dv      = 1'b1;
        tx_byte = 8'h3C;
        @(negedge clk) tx_byte = 8'($urandom);
        @(negedge clk) tx_byte = 8'($urandom);
        check("rst_frame_start_low", serial, 1'b0);
        @(negedge clk) dv = 1'b0;
        repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
        check("rst_frame_bit3", serial, 1'b1);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        check("midrst_serial", serial, 1'b1);
        check("midrst_active", active, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", ready, 1'b1);
        d0   = dones;
        lows = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (serial !== 1'b1) lows++;
        end
        check("midrst_line_low_cycles", lows, 0);
        check("midrst_done_count", dones - d0, 0);
        mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; frame 11 bits
        par_q.delete();
        start_q.delete();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        dv      = 1'b1;
        tx_byte = 8'h07;
        @(negedge clk) tx_byte = 8'h03;
        @(negedge clk) dv = 1'b0;
        drain();
        check("par_frames", par_q.size(), 2);
        if (par_q.size() == 2) begin
            check("par_07", par_q[0], 1'b1);
            check("par_03", par_q[1], 1'b0);
        end
        if (start_q.size() == 2) check("par_frame_len", start_q[1] - start_q[0], 11 * CPB);
`endif

        // All 256 byte values in sequence with random spacing
        f0 = frames;
        d0 = dones;
        for (int i = 0; i < 256; i++) begin
            send_gated(8'(i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        check("seq_frames", frames - f0, 256);
        check("seq_done_count", dones - d0, 256);

        // Random bytes, random spacing
        f0 = frames;
        for (int i = 0; i < 40; i++) begin
            send_gated(8'($urandom));
            repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
        end
        drain();
        check("rand_frames", frames - f0, 40);
        check("leftover_expected", exp_q.size(), 0);
        check("final_idle_serial", serial, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
